// File: rtl/muldiv_sched.sv
// HI/LO scheduler for a MIPS-style multiply/divide unit: fixed-latency ops, mthi/mtlo writes, stall/done signalling.
// Optional accumulate ops (madd/msub) are built only when MULDIV_MADD_EN is defined.
module muldiv_sched #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        md_stall,
  output logic        done,
  output logic        o_dbg_state
);
  // Handshake: an op is accepted on a rising edge where start=1 and the unit is IDLE;
  // md_stall tells the issuing stage to hold while that is not possible.
  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t         r_state, w_next;
  logic [CW-1:0]  r_cnt;
  logic [2:0]     r_op;
  logic [31:0]    r_a, r_b, r_hi, r_lo;
  logic           r_done;

  logic           w_is_mul, w_is_div, w_is_multi, w_accept, w_finish;
  logic [CW-1:0]  w_lat;
  logic [63:0]    w_res;

`ifdef MULDIV_MADD_EN
  assign w_is_mul = (op[2:1] == 2'b00) || (op[2:1] == 2'b11);
`else
  assign w_is_mul = (op[2:1] == 2'b00);
`endif
  assign w_is_div   = (op[2:1] == 2'b01);
  assign w_is_multi = w_is_mul || w_is_div;
  assign w_accept   = (r_state == IDLE) && start && w_is_multi;
  assign w_finish   = (r_state == RUN) && (r_cnt == CW'(1));
  assign w_lat      = w_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = RUN;
      RUN:  if (w_finish) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Division via magnitudes so that 0x80000000 / -1 wraps cleanly instead of overflowing.
  logic        w_sa, w_sb;
  logic [31:0] w_ma, w_mb, w_den, w_uq, w_ur, w_q, w_r;
  logic signed [63:0] w_prod_s;
  logic [63:0] w_prod_u;

  assign w_sa     = (r_op == 3'b010) && r_a[31];
  assign w_sb     = (r_op == 3'b010) && r_b[31];
  assign w_ma     = w_sa ? -r_a : r_a;
  assign w_mb     = w_sb ? -r_b : r_b;
  assign w_den    = (w_mb == 32'd0) ? 32'd1 : w_mb;
  assign w_uq     = w_ma / w_den;
  assign w_ur     = w_ma % w_den;
  assign w_q      = (w_sa ^ w_sb) ? -w_uq : w_uq;
  assign w_r      = w_sa ? -w_ur : w_ur;
  assign w_prod_s = $signed(r_a) * $signed(r_b);
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

  always_comb begin
    w_res = {r_hi, r_lo};
    case (r_op)
      3'b000:          w_res = w_prod_s;
      3'b001:          w_res = w_prod_u;
      3'b010, 3'b011:  if (r_b != 32'd0) w_res = {w_r, w_q};
`ifdef MULDIV_MADD_EN
      3'b110:          w_res = {r_hi, r_lo} + w_prod_s;
      3'b111:          w_res = {r_hi, r_lo} - w_prod_s;
`endif
      default:         w_res = {r_hi, r_lo};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_op   <= 3'd0;
      r_a    <= 32'd0;
      r_b    <= 32'd0;
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_accept) begin
        r_cnt <= w_lat;
        r_op  <= op;
        r_a   <= rs_val;
        r_b   <= rt_val;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_finish) begin
        {r_hi, r_lo} <= w_res;
      end else if ((r_state == IDLE) && start && (op == 3'b100)) begin
        r_hi <= rs_val;
      end else if ((r_state == IDLE) && start && (op == 3'b101)) begin
        r_lo <= rs_val;
      end
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = (r_state == RUN);
  assign md_stall    = busy || (start && w_is_multi);
  assign done        = r_done;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_muldiv_sched.sv
// Directed bench for muldiv_sched: vector table of mult/div results plus hand sequences
// for divide-by-zero, ignored starts, mid-op reset and madd/msub (MULDIV_MADD_EN).
module tb_muldiv_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
  logic [31:0] hi, lo;
  logic        busy, md_stall, done, dbg_state;

  int n_vec = 0;
  int n_err = 0;

  muldiv_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .hi(hi), .lo(lo),
    .busy(busy), .md_stall(md_stall), .done(done), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s act=0x%08h exp=0x%08h", name, act, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int lat);
    int n;
    @(negedge clk);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    #1;
    check({name, "_stall"}, {31'd0, md_stall}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_busy_cycles"}, n, lat);
    check({name, "_done"}, {31'd0, done}, 32'd1);
    check({name, "_hi"}, hi, exp_hi);
    check({name, "_lo"}, lo, exp_lo);
    @(posedge clk); #1;
    check({name, "_done_clr"}, {31'd0, done}, 32'd0);
  endtask

  task automatic move(input logic [2:0] o, input logic [31:0] v);
    @(negedge clk);
    op = o; rs_val = v; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{"mult_neg1x2",   3'b000, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vecs[1] = '{"multu_ffx2",    3'b001, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 5};
    vecs[2] = '{"divu_100_7",    3'b011, 32'd100,      32'd7,        32'd2,        32'd14,       10};
    vecs[3] = '{"div_m7_2",      3'b010, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4] = '{"div_min_m1",    3'b010, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 10};
    vecs[5] = '{"mult_2p16sq",   3'b000, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        5};
    vecs[6] = '{"div_7_m2",      3'b010, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[7] = '{"multu_x16",     3'b001, 32'h12345678, 32'h10,       32'd1,        32'h23456780, 5};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    #1;
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, md_stall}, 32'd0);
    check("rst_state", {31'd0, dbg_state}, 32'd0);

    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].lat);

    // Divide by zero leaves HI/LO alone but still runs full latency
    move(3'b100, 32'h1234);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    move(3'b101, 32'h1234);
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_done", {31'd0, done}, 32'd0);
    run_op("div_by0", 3'b010, 32'd5, 32'd0, 32'h1234, 32'h1234, 10);

    // Starts while busy are ignored; mtlo in the done cycle is accepted
    @(negedge clk);
    op = 3'b000; rs_val = 32'd3; rt_val = 32'd4; start = 1'b1;
    @(posedge clk); #1;
    op = 3'b001; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF;
    check("ign_stall", {31'd0, md_stall}, 32'd1);
    n = 0;
    while (busy && n < 64) begin
      @(posedge clk); #1;
      n++;
      rs_val = rs_val - 32'd1;
    end
    op = 3'b101; rs_val = 32'hAA;
    check("ign_cycles", n, 5);
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_hi", hi, 32'd0);
    check("ign_lo", lo, 32'd12);
    @(posedge clk); #1;
    start = 1'b0;
    check("mtlo_after_lo", lo, 32'hAA);
    check("mtlo_after_hi", hi, 32'd0);
    check("mtlo_after_busy", {31'd0, busy}, 32'd0);
    check("mtlo_after_done", {31'd0, done}, 32'd0);

    // Reset in the third busy cycle of a div aborts it
    move(3'b100, 32'h55);
    @(negedge clk);
    op = 3'b010; rs_val = 32'd9; rt_val = 32'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    reset = 1'b0;
    start = 1'b1; op = 3'b000;
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    repeat (12) begin
      @(posedge clk); #1;
      check("abort_no_done", {31'd0, done | busy}, 32'd0);
    end
    run_op("div_after_rst", 3'b010, 32'd9, 32'd2, 32'd1, 32'd4, 10);

    // Accumulate ops
    move(3'b100, 32'd0);
    move(3'b101, 32'hFFFFFFFF);
`ifdef MULDIV_MADD_EN
    run_op("madd_1x1", 3'b110, 32'd1, 32'd1, 32'd1, 32'd0, 5);
    run_op("msub_2x3", 3'b111, 32'd2, 32'd3, 32'd0, 32'hFFFFFFFA, 5);
`else
    @(negedge clk);
    op = 3'b110; rs_val = 32'd1; rt_val = 32'd1; start = 1'b1;
    #1;
    check("madd_off_stall", {31'd0, md_stall}, 32'd0);
    @(posedge clk); #1;
    op = 3'b111;
    check("madd_off_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check("msub_off_busy", {31'd0, busy}, 32'd0);
    check("madd_off_hi", hi, 32'd0);
    check("madd_off_lo", lo, 32'hFFFFFFFF);
    repeat (6) @(posedge clk); #1;
    check("madd_off_done", {31'd0, done}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/muldiv_sched.md
MULDIV_SCHED -- requirements
Module: muldiv_sched

Interface
REQ-001 SHALL have parameter MULT_LAT, default 5, cycles from mult/madd/msub acceptance to result (>=1).
REQ-002 SHALL have parameter DIV_LAT, default 10, cycles from div/divu acceptance to result (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  E-stage issue strobe for one HI/LO operation.
REQ-006 SHALL have port op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd, 111 msub.
REQ-007 SHALL have port rs_val  input  32  first operand (dividend; mthi/mtlo source).
REQ-008 SHALL have port rt_val  input  32  second operand (divisor).
REQ-009 SHALL have port hi  output  32  architectural HI register.
REQ-010 SHALL have port lo  output  32  architectural LO register.
REQ-011 SHALL have port busy  output  1  multi-cycle operation in flight.
REQ-012 SHALL have port md_stall  output  1  combinational: busy | (start & op is a multi-cycle op); drives hazard stall of mfhi/mflo/mult-family in D.
REQ-013 SHALL have port done  output  1  one-cycle pulse after HI/LO update by a multi-cycle op.

Function
REQ-014 SHALL implement states IDLE and RUN plus a down-counter sized for max(MULT_LAT, DIV_LAT).
REQ-015 In IDLE with start=1 and a valid multi-cycle op at edge k: latch op, rs_val, rt_val; load counter with the op's latency; enter RUN.
REQ-016 busy SHALL be 1 exactly during cycles k+1 .. k+LAT; at edge k+LAT hi/lo update, state returns to IDLE.
REQ-017 done SHALL be 1 only in the cycle after edge k+LAT; a new start in that cycle SHALL be accepted.
REQ-018 start while busy=1 SHALL be ignored: no operand latch, no counter change, no HI/LO change.
REQ-019 mthi/mtlo accepted in IDLE SHALL write hi (resp. lo) with rs_val at the accepting edge; busy and done stay 0.
REQ-020 mult/multu: {hi,lo} = 64-bit signed/unsigned product of latched operands.
REQ-021 div/divu: lo = quotient, hi = remainder; signed quotient truncates toward zero, remainder takes dividend sign.
REQ-022 0x80000000 div 0xFFFFFFFF (signed) SHALL yield lo=0x80000000, hi=0.
REQ-023 Divisor 0 SHALL still take DIV_LAT cycles and pulse done, leaving hi/lo unchanged.
REQ-024 hi/lo SHALL show no intermediate values; they hold between operations.
REQ-025 Unrecognised/disabled op with start=1 SHALL be ignored; md_stall not asserted for it.

Reset
REQ-026 With reset=0 at a rising edge: state IDLE, counter 0, hi=0, lo=0, busy=0, done=0, latched operands 0.
REQ-027 Reset mid-RUN SHALL abort the operation with no HI/LO write and no done pulse.
REQ-028 Reset SHALL take priority over start in the same cycle.

Configuration
REQ-029 Macro MULDIV_MADD_EN defined: op 110 {hi,lo} += signed product, op 111 {hi,lo} -= signed product, 64-bit wrap, latency MULT_LAT.
REQ-030 MULDIV_MADD_EN undefined: ops 110/111 treated per REQ-025; no accumulate datapath synthesised.

Verification
REQ-031 mult rs=0xFFFFFFFF rt=2 -> busy 5 cycles, then hi=0xFFFFFFFF lo=0xFFFFFFFE, done one cycle.
REQ-032 divu rs=100 rt=7 -> busy 10 cycles, then lo=14 hi=2; div rs=-7 rt=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF.
REQ-033 div rs=5 rt=0 with hi=lo=0x1234 -> 10 busy cycles, done=1, hi=lo=0x1234.
REQ-034 mult accepted, then start multu every cycle while busy -> only first result written; mtlo 0xAA after done -> lo=0xAA same edge, busy=0.
REQ-035 reset=0 at cycle 3 of div -> busy=0, hi=lo=0, no done; next div runs full DIV_LAT.
REQ-036 With MULDIV_MADD_EN: {hi,lo}=0x0:0xFFFFFFFF, madd 1*1 -> hi=1 lo=0; without macro same stimulus -> no busy, hi/lo unchanged.
